// File: rtl/camera_pkg.sv
// camera_pkg: definitions shared by the camera capture path.
//   cap_state_t      frame sequencer states
//   DEF_IMAGE_*      default active frame geometry (720p)
//   DEF_SKIP_FRAMES  default number of settling frames after Start
//   cnt_width()      width of a line/pixel counter able to hold n
//                    (never narrower than 12 bits)
package camera_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_INIT,
        ST_IDLE,
        ST_SKIP,
        ST_ARM,
        ST_CAP
    } cap_state_t;

    localparam int DEF_IMAGE_WIDTH  = 1280;
    localparam int DEF_IMAGE_HEIGHT = 720;
    localparam int DEF_SKIP_FRAMES  = 10;

    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 12) ? 12 : w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single quasi-static level.
//   clk   destination clock
//   rst   asynchronous reset, active high (flops clear to RST_VAL)
//   d     asynchronous input level
//   q     synchronised level, 2 clk cycles of latency
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/capture_frame_ctrl.sv
// capture_frame_ctrl: frame-level sequencer between DVP capture and buffering.
// Waits for sensor init, discards SKIP_FRAMES settling frames after Start,
// then forwards only whole frames, counts them and checks their geometry.
//   Clk, Rst_p                  pixel clock, async active-high reset
//   Init_Done                   sensor init done (other clock domain)
//   Start, Stop                 capture request / stop at next frame end
//   DataValid/Hs/Vs/Pixel       DVP capture stream
//   Out_Valid/Hs/Vs/Pixel       gated stream, 1 cycle latency
//   Frame_Start, Frame_Done     1-cycle pulses aligned with Out_Vs edges
//   Frame_Cnt                   forwarded frames since Start (wraps)
//   Size_Err                    sticky line-length / line-count error
//   Busy                        sequencer is active (SKIP, ARM or CAP)
module capture_frame_ctrl
    import camera_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int SKIP_FRAMES  = DEF_SKIP_FRAMES,
    parameter int DATA_W       = 16,
    parameter int FCNT_W       = 16
) (
    input  logic              Clk,
    input  logic              Rst_p,
    input  logic              Init_Done,
    input  logic              Start,
    input  logic              Stop,
    input  logic              DataValid,
    input  logic              DataHs,
    input  logic              DataVs,
    input  logic [DATA_W-1:0] DataPixel,
    output logic              Out_Valid,
    output logic [DATA_W-1:0] Out_Pixel,
    output logic              Out_Hs,
    output logic              Out_Vs,
    output logic              Frame_Start,
    output logic              Frame_Done,
    output logic [FCNT_W-1:0] Frame_Cnt,
    output logic              Size_Err,
    output logic              Busy
);

    localparam int PIX_W  = cnt_width(IMAGE_WIDTH);
    localparam int LINE_W = cnt_width(IMAGE_HEIGHT);
    localparam int SKIP_W = $clog2(SKIP_FRAMES + 2);

    cap_state_t        state, state_nxt;
    logic              init_sync;
    logic              vs_d, hs_d;
    logic              vs_rise, vs_fall, hs_fall;
    logic              start_go, arm_go, frame_end, skip_inc, stop_pend_set;
    logic              cap_active, gate_on;
    logic              stop_pend;
    logic [SKIP_W-1:0] skip_cnt;
    logic [PIX_W-1:0]  pix_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [LINE_W:0]   lines_seen;

    sync_2ff #(.RST_VAL(1'b0)) u_init_sync (
        .clk (Clk),
        .rst (Rst_p),
        .d   (Init_Done),
        .q   (init_sync)
    );

    assign vs_rise = DataVs & ~vs_d;
    assign vs_fall = ~DataVs & vs_d;
    assign hs_fall = ~DataHs & hs_d;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst_p) begin
        if (Rst_p) state <= ST_WAIT_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        start_go      = 1'b0;
        arm_go        = 1'b0;
        frame_end     = 1'b0;
        skip_inc      = 1'b0;
        stop_pend_set = 1'b0;
        if (!init_sync) begin
            state_nxt = ST_WAIT_INIT;
        end else begin
            unique case (state)
                ST_WAIT_INIT: state_nxt = ST_IDLE;
                ST_IDLE: begin
                    if (Start && !Stop) begin
                        start_go  = 1'b1;
                        state_nxt = (SKIP_FRAMES == 0) ? ST_ARM : ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (Stop) begin
                        state_nxt = ST_IDLE;
                    end else if (vs_fall) begin
                        skip_inc = 1'b1;
                        if (int'(skip_cnt) + 1 >= SKIP_FRAMES) state_nxt = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (Stop) begin
                        state_nxt = ST_IDLE;
                    end else if (vs_rise) begin
                        arm_go    = 1'b1;
                        state_nxt = ST_CAP;
                    end
                end
                ST_CAP: begin
                    if (Stop) stop_pend_set = 1'b1;
                    if (vs_fall) begin
                        frame_end = 1'b1;
                        state_nxt = (stop_pend || Stop) ? ST_IDLE : ST_ARM;
                    end
                end
                default: state_nxt = ST_WAIT_INIT;
            endcase
        end
    end

    // The gate opens combinationally on the qualifying vs_rise so that
    // cycle's Vs reaches the output, and stays open for the whole CAP
    // state, so the vs_fall cycle (still in CAP) propagates its low Vs.
    assign cap_active = (state == ST_CAP) && init_sync;
    assign gate_on    = arm_go | cap_active;

    assign Busy = (state != ST_IDLE) && (state != ST_WAIT_INIT);

    // A line ending in the same cycle as the frame still counts.
    assign lines_seen = {1'b0, line_cnt} + (LINE_W + 1)'(hs_fall);

    // ------------------------------------------------------------------
    // Edge history, output registers, counters
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst_p) begin
        if (Rst_p) begin
            // Reset to 1 so a release in mid-frame never looks like a rising edge.
            vs_d        <= 1'b1;
            hs_d        <= 1'b1;
            Out_Valid   <= 1'b0;
            Out_Pixel   <= '0;
            Out_Hs      <= 1'b0;
            Out_Vs      <= 1'b0;
            Frame_Start <= 1'b0;
            Frame_Done  <= 1'b0;
            Frame_Cnt   <= '0;
            Size_Err    <= 1'b0;
            stop_pend   <= 1'b0;
            skip_cnt    <= '0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
        end else begin
            vs_d        <= DataVs;
            hs_d        <= DataHs;
            Out_Valid   <= DataValid & gate_on;
            Out_Hs      <= DataHs & gate_on;
            Out_Vs      <= DataVs & gate_on;
            Out_Pixel   <= gate_on ? DataPixel : '0;
            Frame_Start <= arm_go;
            Frame_Done  <= frame_end;

            if (state_nxt != ST_CAP) stop_pend <= 1'b0;
            else if (stop_pend_set)  stop_pend <= 1'b1;

            if (start_go)      skip_cnt <= '0;
            else if (skip_inc) skip_cnt <= skip_cnt + 1'b1;

            if (start_go)       Frame_Cnt <= '0;
            else if (frame_end) Frame_Cnt <= Frame_Cnt + 1'b1;

            if (start_go) begin
                Size_Err <= 1'b0;
            end else if (cap_active) begin
                if (hs_fall && pix_cnt != PIX_W'(IMAGE_WIDTH))
                    Size_Err <= 1'b1;
                if (vs_fall && lines_seen != (LINE_W + 1)'(IMAGE_HEIGHT))
                    Size_Err <= 1'b1;
            end

            // DataValid is only asserted while Hs is high, so a pixel never
            // coincides with the hs_fall that closes its line.
            if (state == ST_ARM) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
            end else if (cap_active) begin
                if (hs_fall)
                    pix_cnt <= '0;
                else if (DataValid && pix_cnt != '1)
                    pix_cnt <= pix_cnt + 1'b1;
                if (hs_fall && line_cnt != '1)
                    line_cnt <= line_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_capture_frame_ctrl.sv
// tb_capture_frame_ctrl: directed frame vectors for capture_frame_ctrl on a
// reduced 8x4 geometry with two skip frames and a 2-bit frame counter.
module tb_capture_frame_ctrl;

    localparam int W      = 8;
    localparam int H      = 4;
    localparam int DATA_W = 16;
    localparam int FCNT_W = 2;

    logic              Clk = 1'b0;
    logic              Rst_p;
    logic              Init_Done;
    logic              Start;
    logic              Stop;
    logic              DataValid;
    logic              DataHs;
    logic              DataVs;
    logic [DATA_W-1:0] DataPixel;
    logic              Out_Valid;
    logic [DATA_W-1:0] Out_Pixel;
    logic              Out_Hs;
    logic              Out_Vs;
    logic              Frame_Start;
    logic              Frame_Done;
    logic [FCNT_W-1:0] Frame_Cnt;
    logic              Size_Err;
    logic              Busy;

    capture_frame_ctrl #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .SKIP_FRAMES  (2),
        .DATA_W       (DATA_W),
        .FCNT_W       (FCNT_W)
    ) dut (
        .Clk         (Clk),
        .Rst_p       (Rst_p),
        .Init_Done   (Init_Done),
        .Start       (Start),
        .Stop        (Stop),
        .DataValid   (DataValid),
        .DataHs      (DataHs),
        .DataVs      (DataVs),
        .DataPixel   (DataPixel),
        .Out_Valid   (Out_Valid),
        .Out_Pixel   (Out_Pixel),
        .Out_Hs      (Out_Hs),
        .Out_Vs      (Out_Vs),
        .Frame_Start (Frame_Start),
        .Frame_Done  (Frame_Done),
        .Frame_Cnt   (Frame_Cnt),
        .Size_Err    (Size_Err),
        .Busy        (Busy)
    );

    always #5 Clk = ~Clk;

    // Running totals of output activity; tests take deltas around a frame.
    int unsigned       n_valid = 0, n_fs = 0, n_fd = 0, n_pix_bad = 0;
    logic              prev_valid = 1'b0;
    logic [DATA_W-1:0] prev_pixel = '0;

    always @(negedge Clk) begin
        if (Out_Valid) begin
            n_valid++;
            if (!(prev_valid && Out_Pixel == prev_pixel)) n_pix_bad++;
        end
        if (Frame_Start) n_fs++;
        if (Frame_Done)  n_fd++;
        prev_valid = DataValid;
        prev_pixel = DataPixel;
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic begin_frame(input bit start, input bit both);
        if (start || both) begin
            tick; Start = 1'b1; Stop = both;
            tick; Start = 1'b0; Stop = 1'b0;
        end
        repeat (2) tick;
        tick; DataVs = 1'b1;
        repeat (2) tick;
    endtask

    task automatic drive_line(input int width, input int stop_at);
        for (int p = 0; p < width; p++) begin
            tick;
            DataHs    = 1'b1;
            DataValid = 1'b1;
            DataPixel = DATA_W'($urandom);
            Stop      = (p == stop_at);
        end
        tick; DataHs = 1'b0; DataValid = 1'b0; Stop = 1'b0;
        tick;
    endtask

    task automatic end_frame;
        tick; DataVs = 1'b0;
        repeat (4) tick;
    endtask

    task automatic run_frame(input bit start, input bit both, input int lines,
                             input int short_line, input int stop_line);
        begin_frame(start, both);
        for (int l = 0; l < lines; l++)
            drive_line((l == short_line) ? W - 1 : W, (l == stop_line) ? 3 : -1);
        end_frame;
    endtask

    typedef struct {
        bit start;      // pulse Start in the blanking before the frame
        bit both;       // pulse Start and Stop together instead
        int lines;
        int short_line; // line index carrying W-1 pixels, -1 none
        int stop_line;  // line index during which Stop pulses, -1 none
        int exp_valid;  // forwarded pixels
        int exp_fs;
        int exp_fd;
        int exp_cnt;    // Frame_Cnt after the frame
        int exp_err;    // Size_Err after the frame
        int exp_busy;   // Busy after the frame
    } vec_t;

    vec_t vecs[18];

    int unsigned s_valid, s_fs, s_fd, s_bad;
    int          drop_k;

    task automatic snap;
        s_valid = n_valid; s_fs = n_fs; s_fd = n_fd; s_bad = n_pix_bad;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1, 0, 4, -1, -1,  0, 0, 0, 0, 0, 1};
        vecs[1]  = '{0, 0, 4, -1, -1,  0, 0, 0, 0, 0, 1};
        vecs[2]  = '{0, 0, 4, -1, -1, 32, 1, 1, 1, 0, 1};
        vecs[3]  = '{0, 0, 4, -1, -1, 32, 1, 1, 2, 0, 1};
        vecs[4]  = '{0, 0, 4, -1,  1, 32, 1, 1, 3, 0, 0};
        vecs[5]  = '{0, 0, 4, -1, -1,  0, 0, 0, 3, 0, 0};
        vecs[6]  = '{1, 0, 4, -1, -1,  0, 0, 0, 0, 0, 1};
        vecs[7]  = '{0, 0, 4, -1, -1,  0, 0, 0, 0, 0, 1};
        vecs[8]  = '{0, 0, 4,  2, -1, 31, 1, 1, 1, 1, 1};
        vecs[9]  = '{0, 0, 3, -1,  0, 24, 1, 1, 2, 1, 0};
        vecs[10] = '{1, 0, 4, -1, -1,  0, 0, 0, 0, 0, 1};
        vecs[11] = '{0, 0, 4, -1, -1,  0, 0, 0, 0, 0, 1};
        vecs[12] = '{0, 0, 3, -1, -1, 24, 1, 1, 1, 1, 1};
        vecs[13] = '{1, 0, 4, -1, -1, 32, 1, 1, 2, 1, 1};
        vecs[14] = '{0, 0, 4, -1, -1, 32, 1, 1, 3, 1, 1};
        vecs[15] = '{0, 0, 4, -1, -1, 32, 1, 1, 0, 1, 1};
        vecs[16] = '{0, 0, 4, -1,  1, 32, 1, 1, 1, 1, 0};
        vecs[17] = '{0, 1, 4, -1, -1,  0, 0, 0, 1, 1, 0};

        Rst_p = 1'b1; Init_Done = 1'b1; Start = 1'b0; Stop = 1'b0;
        DataValid = 1'b0; DataHs = 1'b0; DataVs = 1'b0; DataPixel = '0;
        repeat (3) tick;
        check("reset outputs",
              {Out_Valid, Out_Pixel, Out_Hs, Out_Vs, Frame_Start, Frame_Done,
               Frame_Cnt, Size_Err, Busy}, 0);
        Rst_p = 1'b0;
        repeat (6) tick;
        check("idle busy", Busy, 0);

        for (int i = 0; i < 18; i++) begin
            snap;
            run_frame(vecs[i].start, vecs[i].both, vecs[i].lines,
                      vecs[i].short_line, vecs[i].stop_line);
            check($sformatf("v%0d valid", i), n_valid - s_valid, vecs[i].exp_valid);
            check($sformatf("v%0d frame_start", i), n_fs - s_fs, vecs[i].exp_fs);
            check($sformatf("v%0d frame_done", i), n_fd - s_fd, vecs[i].exp_fd);
            check($sformatf("v%0d pixel", i), n_pix_bad - s_bad, 0);
            check($sformatf("v%0d frame_cnt", i), Frame_Cnt, vecs[i].exp_cnt);
            check($sformatf("v%0d size_err", i), Size_Err, vecs[i].exp_err);
            check($sformatf("v%0d busy", i), Busy, vecs[i].exp_busy);
        end

        // Reset asserted mid-line of a forwarded frame with Vs high.
        run_frame(1, 0, 4, -1, -1);
        run_frame(0, 0, 4, -1, -1);
        begin_frame(0, 0);
        drive_line(W, -1);
        for (int p = 0; p < 4; p++) begin
            tick; DataHs = 1'b1; DataValid = 1'b1; DataPixel = DATA_W'($urandom);
        end
        tick;
        check("pre-reset out_vs", Out_Vs, 1);
        #2 Rst_p = 1'b1;
        #1;
        check("async reset outputs",
              {Out_Valid, Out_Pixel, Out_Hs, Out_Vs, Frame_Start, Frame_Done,
               Frame_Cnt, Size_Err, Busy}, 0);
        repeat (2) tick;
        Rst_p = 1'b0;
        snap;
        for (int p = 4; p < W; p++) begin
            tick; DataHs = 1'b1; DataValid = 1'b1; DataPixel = DATA_W'($urandom);
        end
        tick; DataHs = 1'b0; DataValid = 1'b0;
        tick;
        drive_line(W, -1);
        drive_line(W, -1);
        end_frame;
        run_frame(0, 0, 4, -1, -1);
        check("post-reset valid", n_valid - s_valid, 0);
        check("post-reset frame_start", n_fs - s_fs, 0);
        check("post-reset busy", Busy, 0);

        // Init_Done dropped in the middle of a forwarded line.
        run_frame(1, 0, 4, -1, -1);
        run_frame(0, 0, 4, -1, -1);
        begin_frame(0, 0);
        drive_line(W, -1);
        snap;
        drop_k = 0;
        for (int k = 1; k <= 6; k++) begin
            tick;
            if (k == 1) Init_Done = 1'b0;
            DataHs = 1'b1; DataValid = 1'b1; DataPixel = DATA_W'($urandom);
            if (k > 2 && drop_k == 0 && !Out_Valid) drop_k = k;
        end
        check("init drop gate latency ok", (drop_k >= 3 && drop_k <= 4), 1);
        tick; DataHs = 1'b0; DataValid = 1'b0;
        tick;
        drive_line(W, -1);
        end_frame;
        check("init drop frame_done", n_fd - s_fd, 0);
        check("init drop busy", Busy, 0);
        Init_Done = 1'b1;
        repeat (6) tick;
        snap;
        run_frame(0, 0, 4, -1, -1);
        check("after init valid", n_valid - s_valid, 0);
        check("after init busy", Busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
